issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard.sv | 207 ++++++++++++++++++++
 tb/tb_issue_scoreboard.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// ---------------------------------------------------------------------------
// IssueScoreboard
//   Issue-stage scoreboard for a machine with three execution units
//   (AluMisc, Mem, Mult) that share one register-file writeback port.
//   A shift register of reservation slots tracks, per future cycle, which
//   result will occupy the writeback port. Slot 0 is the current writeback
//   cycle. A request is granted in the same cycle it is presented unless it
//   has a structural, RAW, WAW or Mult-busy hazard.
//
// Ports
//   clock          : rising-edge clock
//   reset          : asynchronous reset, active low
//   req_valid      : Decode presents an instruction
//   req_unit       : 0=AluMisc, 1=Mem, 2=Mult, 3=illegal
//   req_addra/b    : source register numbers
//   req_usea/b     : the matching source is actually read
//   req_writereg   : the instruction writes a register
//   req_regdest    : destination register
//   grant          : the instruction issues this cycle
//   iss_stall      : hold Fetch and Decode this cycle
//   iss_*_oper     : one-hot start pulse to the selected unit
//   wb_exp_valid   : a scheduled result owns the writeback port this cycle
//   wb_exp_unit    : unit of that result
//   wb_exp_regdest : destination register of that result
//   illegal_req    : request with req_unit=3 (dropped)
//   occupancy      : number of valid reservation slots
// ---------------------------------------------------------------------------
module issue_scoreboard #(
  parameter int LAT_AM  = 4,
  parameter int LAT_MEM = 3,
  parameter int LAT_MUL = 6,
  parameter int DEPTH   = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_unit,
  input  logic [4:0] req_addra,
  input  logic [4:0] req_addrb,
  input  logic       req_usea,
  input  logic       req_useb,
  input  logic       req_writereg,
  input  logic [4:0] req_regdest,
  output logic       grant,
  output logic       iss_stall,
  output logic       iss_am_oper,
  output logic       iss_mem_oper,
  output logic       iss_mul_oper,
  output logic       wb_exp_valid,
  output logic [1:0] wb_exp_unit,
  output logic [4:0] wb_exp_regdest,
  output logic       illegal_req,
  output logic [2:0] occupancy
);

  localparam logic [1:0] UNIT_AM  = 2'd0;
  localparam logic [1:0] UNIT_MEM = 2'd1;
  localparam logic [1:0] UNIT_MUL = 2'd2;
  localparam logic [1:0] UNIT_ILL = 2'd3;

  // Busy counter must hold LAT_MUL-1.
  localparam int MBW = (LAT_MUL > 1) ? $clog2(LAT_MUL) : 1;
  localparam logic [MBW-1:0] MUL_LOAD = MBW'(LAT_MUL - 1);

  logic [DEPTH-1:0] r_slotValid;
  logic [1:0]       r_slotUnit [DEPTH];
  logic [4:0]       r_slotDest [DEPTH];
  logic [MBW-1:0]   r_mulBusy;
  logic [2:0]       r_occupancy;

  logic             w_isAm;
  logic             w_isMem;
  logic             w_isMul;
  logic             w_legal;
  logic             w_writes;
  logic             w_structHaz;
  logic             w_rawHaz;
  logic             w_wawHaz;
  logic             w_mulHaz;
  logic             w_grant;
  logic             w_reserve;

  logic [DEPTH-1:0] w_nextValid;
  logic [1:0]       w_nextUnit [DEPTH];
  logic [4:0]       w_nextDest [DEPTH];
  logic [MBW-1:0]   w_nextMulBusy;
  logic [2:0]       w_nextOcc;

  assign w_isAm   = (req_unit == UNIT_AM);
  assign w_isMem  = (req_unit == UNIT_MEM);
  assign w_isMul  = (req_unit == UNIT_MUL);
  assign w_legal  = (req_unit != UNIT_ILL);
  // Writes to r0 are discarded by the register file, so they reserve nothing.
  assign w_writes = req_writereg && (req_regdest != 5'd0);

  // Hazard scan over every valid slot, slot 0 included (no bypass path).
  // The structural check looks at slot L because that entry is about to
  // shift into L-1, the slot a new reservation would claim. With L equal to
  // DEPTH no slot index matches, so there is never a conflict.
  always_comb begin
    w_rawHaz    = 1'b0;
    w_wawHaz    = 1'b0;
    w_structHaz = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_slotValid[k]) begin
        if (req_usea && (req_addra != 5'd0) && (req_addra == r_slotDest[k]))
          w_rawHaz = 1'b1;
        if (req_useb && (req_addrb != 5'd0) && (req_addrb == r_slotDest[k]))
          w_rawHaz = 1'b1;
        if (w_writes && (req_regdest == r_slotDest[k]))
          w_wawHaz = 1'b1;
        if (w_writes && ((w_isAm  && (k == LAT_AM))  ||
                         (w_isMem && (k == LAT_MEM)) ||
                         (w_isMul && (k == LAT_MUL))))
          w_structHaz = 1'b1;
      end
    end
  end

  assign w_mulHaz  = w_isMul && (r_mulBusy != '0);
  assign w_grant   = req_valid && w_legal &&
                     !(w_structHaz || w_rawHaz || w_wawHaz || w_mulHaz);
  assign w_reserve = w_grant && w_writes;

  // Next slot contents: everything moves one slot toward writeback, the top
  // slot empties, and a granted reservation overrides slot L-1.
  always_comb begin
    w_nextValid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_nextUnit[k] = 2'd0;
      w_nextDest[k] = 5'd0;
    end
    for (int k = 0; k < DEPTH - 1; k++) begin
      w_nextValid[k] = r_slotValid[k+1];
      w_nextUnit[k]  = r_slotUnit[k+1];
      w_nextDest[k]  = r_slotDest[k+1];
    end
    if (w_reserve) begin
      if (w_isAm) begin
        w_nextValid[LAT_AM-1] = 1'b1;
        w_nextUnit[LAT_AM-1]  = UNIT_AM;
        w_nextDest[LAT_AM-1]  = req_regdest;
      end
      if (w_isMem) begin
        w_nextValid[LAT_MEM-1] = 1'b1;
        w_nextUnit[LAT_MEM-1]  = UNIT_MEM;
        w_nextDest[LAT_MEM-1]  = req_regdest;
      end
      if (w_isMul) begin
        w_nextValid[LAT_MUL-1] = 1'b1;
        w_nextUnit[LAT_MUL-1]  = UNIT_MUL;
        w_nextDest[LAT_MUL-1]  = req_regdest;
      end
    end
  end

  // Occupancy is registered from the next-state valids so that the output
  // always matches the slots currently held.
  always_comb begin
    w_nextOcc = 3'd0;
    for (int k = 0; k < DEPTH; k++) begin
      w_nextOcc = w_nextOcc + {2'd0, w_nextValid[k]};
    end
  end

  // The multiplier is unpipelined: any Mult grant blocks further Mult
  // requests for LAT_MUL-1 following cycles, whether or not it writes.
  always_comb begin
    w_nextMulBusy = r_mulBusy;
    if (w_grant && w_isMul)
      w_nextMulBusy = MUL_LOAD;
    else if (r_mulBusy != '0)
      w_nextMulBusy = r_mulBusy - MBW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_slotValid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_slotUnit[k] <= 2'd0;
        r_slotDest[k] <= 5'd0;
      end
      r_mulBusy   <= '0;
      r_occupancy <= 3'd0;
    end else begin
      r_slotValid <= w_nextValid;
      for (int k = 0; k < DEPTH; k++) begin
        r_slotUnit[k] <= w_nextUnit[k];
        r_slotDest[k] <= w_nextDest[k];
      end
      r_mulBusy   <= w_nextMulBusy;
      r_occupancy <= w_nextOcc;
    end
  end

  assign grant          = w_grant;
  assign iss_stall      = req_valid && w_legal && !w_grant;
  assign iss_am_oper    = w_grant && w_isAm;
  assign iss_mem_oper   = w_grant && w_isMem;
  assign iss_mul_oper   = w_grant && w_isMul;
  assign illegal_req    = req_valid && !w_legal;
  assign wb_exp_valid   = r_slotValid[0];
  assign wb_exp_unit    = r_slotUnit[0];
  assign wb_exp_regdest = r_slotDest[0];
  assign occupancy      = r_occupancy;

endmodule

// File: tb/tb_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_issue_scoreboard
//   Bench for issue_scoreboard. The reference model keeps a list of pending
//   results, each tagged with the absolute cycle in which it will own the
//   writeback port, plus the first cycle in which the multiplier is free.
//   One process compares every DUT output against that model each cycle;
//   the directed sequences add literal expectations on top.
//   Cycle numbering: a request presented in cycle c and granted there writes
//   back in cycle c+L.
// ---------------------------------------------------------------------------
module tb_issue_scoreboard;

  localparam int LAT_AM  = 4;
  localparam int LAT_MEM = 3;
  localparam int LAT_MUL = 6;
  localparam int DEPTH   = 6;

  localparam logic [1:0] AM  = 2'd0;
  localparam logic [1:0] MEM = 2'd1;
  localparam logic [1:0] MUL = 2'd2;
  localparam logic [1:0] ILL = 2'd3;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_unit;
  logic [4:0] req_addra;
  logic [4:0] req_addrb;
  logic       req_usea;
  logic       req_useb;
  logic       req_writereg;
  logic [4:0] req_regdest;
  logic       grant;
  logic       iss_stall;
  logic       iss_am_oper;
  logic       iss_mem_oper;
  logic       iss_mul_oper;
  logic       wb_exp_valid;
  logic [1:0] wb_exp_unit;
  logic [4:0] wb_exp_regdest;
  logic       illegal_req;
  logic [2:0] occupancy;

  always #5 clock = ~clock;

  issue_scoreboard #(
    .LAT_AM (LAT_AM),
    .LAT_MEM(LAT_MEM),
    .LAT_MUL(LAT_MUL),
    .DEPTH  (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_unit      (req_unit),
    .req_addra     (req_addra),
    .req_addrb     (req_addrb),
    .req_usea      (req_usea),
    .req_useb      (req_useb),
    .req_writereg  (req_writereg),
    .req_regdest   (req_regdest),
    .grant         (grant),
    .iss_stall     (iss_stall),
    .iss_am_oper   (iss_am_oper),
    .iss_mem_oper  (iss_mem_oper),
    .iss_mul_oper  (iss_mul_oper),
    .wb_exp_valid  (wb_exp_valid),
    .wb_exp_unit   (wb_exp_unit),
    .wb_exp_regdest(wb_exp_regdest),
    .illegal_req   (illegal_req),
    .occupancy     (occupancy)
  );

  int   checkCount = 0;
  int   passCount  = 0;
  int   cyc        = 0;
  logic modelEn    = 1'b0;

  typedef struct {
    int         wb;
    logic [1:0] unit;
    logic [4:0] dest;
  } pend_t;

  pend_t pend[$];
  pend_t keep[$];
  pend_t newEntry;
  int    mulFreeAt = 0;

  // Model scratch, owned by the model process only
  logic       lastGrant;
  logic       lastWrites;
  logic [1:0] lastUnit;
  logic [4:0] lastDest;
  logic       eGrant, eRaw, eWaw, eTaken, eMulBusy, eLegal, eWrites;
  logic       eWbV;
  logic [1:0] eWbU;
  logic [4:0] eWbD;
  int         eOcc;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] u,
                               input logic [4:0] a, input logic ua,
                               input logic [4:0] b, input logic ub,
                               input logic w, input logic [4:0] d);
    req_valid    = v;
    req_unit     = u;
    req_addra    = a;
    req_usea     = ua;
    req_addrb    = b;
    req_useb     = ub;
    req_writereg = w;
    req_regdest  = d;
  endtask

  task automatic idle();
    applyStimulus(1'b0, AM, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  function automatic int latOf(input logic [1:0] u);
    case (u)
      AM:      return LAT_AM;
      MEM:     return LAT_MEM;
      MUL:     return LAT_MUL;
      default: return 0;
    endcase
  endfunction

  // Reference model and per-cycle comparison
  initial begin
    lastGrant  = 1'b0;
    lastWrites = 1'b0;
    lastUnit   = 2'd0;
    lastDest   = 5'd0;
    forever begin
      @(negedge clock);
      if (modelEn) begin
        if (!reset) begin
          pend.delete();
          mulFreeAt = 0;
        end
        eWrites = req_writereg && (req_regdest != 5'd0);
        eLegal  = (req_unit != ILL);
        eRaw = 1'b0; eWaw = 1'b0; eTaken = 1'b0;
        eWbV = 1'b0; eWbU = 2'd0; eWbD = 5'd0; eOcc = 0;
        foreach (pend[i]) begin
          if (pend[i].wb >= cyc) begin
            eOcc++;
            if (pend[i].wb == cyc) begin
              eWbV = 1'b1;
              eWbU = pend[i].unit;
              eWbD = pend[i].dest;
            end
            if (req_usea && req_addra != 5'd0 && req_addra == pend[i].dest) eRaw = 1'b1;
            if (req_useb && req_addrb != 5'd0 && req_addrb == pend[i].dest) eRaw = 1'b1;
            if (pend[i].dest == req_regdest) eWaw = 1'b1;
            // the writeback cycle this request would claim is already owned
            if (eLegal && pend[i].wb == cyc + latOf(req_unit)) eTaken = 1'b1;
          end
        end
        eMulBusy = (req_unit == MUL) && (cyc < mulFreeAt);
        eGrant   = req_valid && eLegal && !eRaw && !eMulBusy &&
                   !(eWrites && (eWaw || eTaken));

        checkOutput("grant",        grant,        eGrant);
        checkOutput("iss_stall",    iss_stall,    req_valid && eLegal && !eGrant);
        checkOutput("iss_am_oper",  iss_am_oper,  eGrant && req_unit == AM);
        checkOutput("iss_mem_oper", iss_mem_oper, eGrant && req_unit == MEM);
        checkOutput("iss_mul_oper", iss_mul_oper, eGrant && req_unit == MUL);
        checkOutput("illegal_req",  illegal_req,  req_valid && !eLegal);
        checkOutput("wb_exp_valid", wb_exp_valid, eWbV);
        if (eWbV) begin
          checkOutput("wb_exp_unit",    wb_exp_unit,    eWbU);
          checkOutput("wb_exp_regdest", wb_exp_regdest, eWbD);
        end
        checkOutput("occupancy", occupancy, eOcc);

        lastGrant  = eGrant;
        lastWrites = eWrites;
        lastUnit   = req_unit;
        lastDest   = req_regdest;
      end
      @(posedge clock);
      if (!reset) begin
        pend.delete();
        mulFreeAt = 0;
      end else if (modelEn && lastGrant) begin
        if (lastWrites) begin
          newEntry.wb   = cyc + latOf(lastUnit);
          newEntry.unit = lastUnit;
          newEntry.dest = lastDest;
          pend.push_back(newEntry);
        end
        if (lastUnit == MUL) mulFreeAt = cyc + LAT_MUL;
      end
      lastGrant = 1'b0;
      cyc++;
      keep.delete();
      foreach (pend[i]) if (pend[i].wb >= cyc) keep.push_back(pend[i]);
      pend = keep;
    end
  end

  // Stimulus with literal expectations
  initial begin
    logic [1:0] ru;
    int         pick;
    reset = 1'b1;
    idle();
    #2 reset = 1'b0;
    modelEn = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    @(negedge clock);
    checkOutput("rst_occupancy", occupancy, 0);
    checkOutput("rst_wb_valid", wb_exp_valid, 0);

    // AluMisc writing r3: writeback exactly 4 cycles after the grant
    nextCycle();
    applyStimulus(1'b1, AM, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3);
    @(negedge clock);
    checkOutput("am_grant", grant, 1);
    checkOutput("am_oper", iss_am_oper, 1);
    nextCycle();
    idle();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      checkOutput("am_wb_valid", wb_exp_valid, (i == 4) ? 1 : 0);
      if (i == 4) begin
        checkOutput("am_wb_dest", wb_exp_regdest, 3);
        checkOutput("am_wb_unit", wb_exp_unit, 0);
      end
      nextCycle();
    end
    repeat (8) nextCycle();

    // Mult r5, then AluMisc r6 two cycles later: slot 4 held, one stall
    applyStimulus(1'b1, MUL, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5);
    @(negedge clock);
    checkOutput("mul5_grant", grant, 1);
    checkOutput("mul5_oper", iss_mul_oper, 1);
    nextCycle();
    idle();
    nextCycle();
    applyStimulus(1'b1, AM, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd6);
    @(negedge clock);
    checkOutput("am6_c2_stall", iss_stall, 1);
    checkOutput("am6_c2_grant", grant, 0);
    nextCycle();
    @(negedge clock);
    checkOutput("am6_c3_grant", grant, 1);
    checkOutput("am6_c3_stall", iss_stall, 0);
    nextCycle();
    idle();
    repeat (8) nextCycle();

    // Mem load r2 then a reader of r2: stalled until r2 leaves slot 0
    applyStimulus(1'b1, MEM, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2);
    @(negedge clock);
    checkOutput("mem2_grant", grant, 1);
    checkOutput("mem2_oper", iss_mem_oper, 1);
    for (int i = 1; i <= 4; i++) begin
      nextCycle();
      applyStimulus(1'b1, AM, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
      @(negedge clock);
      checkOutput("raw_stall", iss_stall, (i < 4) ? 1 : 0);
      checkOutput("raw_grant", grant, (i == 4) ? 1 : 0);
    end
    nextCycle();
    idle();
    repeat (8) nextCycle();

    // Back-to-back Mult: second one waits out the busy window
    applyStimulus(1'b1, MUL, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7);
    @(negedge clock);
    checkOutput("mul7_grant", grant, 1);
    for (int i = 1; i <= 6; i++) begin
      nextCycle();
      applyStimulus(1'b1, MUL, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8);
      @(negedge clock);
      checkOutput("mul8_grant", grant, (i == 6) ? 1 : 0);
      checkOutput("mul8_stall", iss_stall, (i < 6) ? 1 : 0);
    end
    nextCycle();
    idle();
    repeat (10) nextCycle();

    // Illegal unit: dropped, no stall, nothing reserved
    applyStimulus(1'b1, ILL, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9);
    @(negedge clock);
    checkOutput("ill_flag", illegal_req, 1);
    checkOutput("ill_grant", grant, 0);
    checkOutput("ill_stall", iss_stall, 0);
    checkOutput("ill_mul_oper", iss_mul_oper, 0);
    nextCycle();
    idle();
    @(negedge clock);
    checkOutput("ill_occupancy", occupancy, 0);
    checkOutput("ill_flag_clear", illegal_req, 0);

    // Three reservations in flight, then reset
    nextCycle();
    applyStimulus(1'b1, AM, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10);
    @(negedge clock);
    checkOutput("r10_grant", grant, 1);
    nextCycle();
    applyStimulus(1'b1, MUL, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd11);
    @(negedge clock);
    checkOutput("r11_grant", grant, 1);
    nextCycle();
    applyStimulus(1'b1, MEM, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12);
    @(negedge clock);
    checkOutput("r12_grant", grant, 1);
    nextCycle();
    idle();
    @(negedge clock);
    checkOutput("pre_rst_occupancy", occupancy, 3);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checkOutput("in_rst_occupancy", occupancy, 0);
    checkOutput("in_rst_wb_valid", wb_exp_valid, 0);
    applyStimulus(1'b1, AM, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd20);
    #1;
    checkOutput("in_rst_grant", grant, 1);
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b1, MUL, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    @(negedge clock);
    checkOutput("post_rst_mul_grant", grant, 1);
    nextCycle();
    idle();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checkOutput("post_rst_wb_valid", wb_exp_valid, 0);
      nextCycle();
    end

    // Randomized traffic on a small register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b0;
        idle();
        nextCycle();
        reset = 1'b1;
      end
      pick = int'($urandom_range(0, 9));
      ru   = (pick < 4) ? AM : (pick < 6) ? MEM : (pick < 9) ? MUL : ILL;
      applyStimulus($urandom_range(0, 9) < 7, ru,
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)));
      nextCycle();
    end
    idle();
    repeat (10) nextCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
